// File: rtl/pipe_issue_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : pipe_issue_scheduler
// Description : Round-robin, credit-gated issue into a fixed-latency pipeline
//               with tagged in-order result return and a flush/drain handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_issue_scheduler #(
    parameter int NUM_IN = 4,
    parameter int WIDTH  = 32,
    parameter int RWIDTH = 32,
    parameter int LAT    = 8,
    parameter int DEPTH  = 16,
    parameter int ID_W   = $clog2(NUM_IN)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_IN-1:0]       valid_us,
    input  logic [NUM_IN*WIDTH-1:0] data_us,
    output logic [NUM_IN-1:0]       stall_us,
    output logic                    pipe_valid,
    output logic [WIDTH-1:0]        pipe_data,
    input  logic                    ret_valid,
    input  logic [RWIDTH-1:0]       ret_data,
    output logic                    valid_ds,
    output logic [RWIDTH-1:0]       data_ds,
    output logic [ID_W-1:0]         id_ds,
    input  logic                    stall_ds,
    input  logic                    flush,
    output logic                    flush_done,
    output logic                    err
);

    localparam int         c_CW    = $clog2(DEPTH + 1);
    localparam int         c_PW    = $clog2(DEPTH);
    localparam logic [1:0] c_RUN   = 2'd0;
    localparam logic [1:0] c_DRAIN = 2'd1;
    localparam logic [1:0] c_DONE  = 2'd2;
    localparam logic [LAT-1:0] c_TAIL_MASK = LAT'(1) << (LAT - 1);

    logic [1:0]        r_state;
    logic [1:0]        w_state_next;
    logic [ID_W-1:0]   r_rr_ptr;
    logic [c_CW-1:0]   r_credits;
    logic              w_grant_en;
    logic              w_grant;
    logic [ID_W-1:0]   w_gnt_idx;
    logic [ID_W-1:0]   w_scan_idx;
    logic [NUM_IN-1:0] w_grant_vec;

    logic              r_pipe_valid;
    logic [WIDTH-1:0]  r_pipe_data;
    logic [ID_W-1:0]   r_issue_tag;

    logic [LAT-1:0]    r_tp_valid;
    logic [ID_W-1:0]   r_tp_tag [LAT];
    logic              w_tail_valid;
    logic              w_fifo_wr;
    logic              r_err;

    logic [RWIDTH-1:0] r_fifo_data [DEPTH];
    logic [ID_W-1:0]   r_fifo_id [DEPTH];
    logic [c_PW-1:0]   r_wptr;
    logic [c_PW-1:0]   r_rptr;
    logic [c_CW-1:0]   r_count;
    logic [c_CW-1:0]   w_count_next;
    logic              w_pop;
    logic              w_drained;

    // Gating on rst keeps every requester stalled while reset is held.
    assign w_grant_en = rst && (r_state == c_RUN) && (r_credits != '0);

    // Descending scan so the nearest requester at or after rr_ptr wins.
    always_comb begin
        w_grant    = 1'b0;
        w_gnt_idx  = '0;
        w_scan_idx = '0;
        for (int k = NUM_IN - 1; k >= 0; k--) begin
            w_scan_idx = ID_W'((int'(r_rr_ptr) + k) % NUM_IN);
            if (valid_us[w_scan_idx]) begin
                w_grant   = w_grant_en;
                w_gnt_idx = w_scan_idx;
            end
        end
    end

    assign w_grant_vec = w_grant ? (NUM_IN'(1) << w_gnt_idx) : '0;
    assign stall_us    = valid_us & ~w_grant_vec;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pipe_valid <= 1'b0;
            r_pipe_data  <= '0;
            r_issue_tag  <= '0;
            r_rr_ptr     <= '0;
        end else begin
            r_pipe_valid <= w_grant;
            if (w_grant) begin
                r_pipe_data <= data_us[w_gnt_idx*WIDTH +: WIDTH];
                r_issue_tag <= w_gnt_idx;
                r_rr_ptr    <= (w_gnt_idx == ID_W'(NUM_IN - 1)) ? '0 : w_gnt_idx + ID_W'(1);
            end
        end
    end

    // Tag pipe tail lines up with ret_valid for the same issue.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_tp_valid <= '0;
            for (int s = 0; s < LAT; s++) r_tp_tag[s] <= '0;
        end else begin
            r_tp_valid[0] <= r_pipe_valid;
            r_tp_tag[0]   <= r_issue_tag;
            for (int s = 1; s < LAT; s++) begin
                r_tp_valid[s] <= r_tp_valid[s-1];
                r_tp_tag[s]   <= r_tp_tag[s-1];
            end
        end
    end

    assign w_tail_valid = r_tp_valid[LAT-1];
    assign w_fifo_wr    = ret_valid && w_tail_valid;
    assign w_pop        = (r_count != '0) && !stall_ds;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_err <= 1'b0;
        else      r_err <= r_err | (ret_valid != w_tail_valid);
    end

    always_ff @(posedge clk) begin
        if (w_fifo_wr) begin
            r_fifo_data[r_wptr] <= ret_data;
            r_fifo_id[r_wptr]   <= r_tp_tag[LAT-1];
        end
    end

    always_comb begin
        w_count_next = r_count;
        case ({w_fifo_wr, w_pop})
            2'b10:   w_count_next = r_count + c_CW'(1);
            2'b01:   w_count_next = r_count - c_CW'(1);
            default: w_count_next = r_count;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wptr    <= '0;
            r_rptr    <= '0;
            r_count   <= '0;
            r_credits <= c_CW'(DEPTH);
        end else begin
            r_count <= w_count_next;
            if (w_fifo_wr) r_wptr <= (r_wptr == c_PW'(DEPTH - 1)) ? '0 : r_wptr + c_PW'(1);
            if (w_pop)     r_rptr <= (r_rptr == c_PW'(DEPTH - 1)) ? '0 : r_rptr + c_PW'(1);
            case ({w_grant, w_pop})
                2'b10:   r_credits <= r_credits - c_CW'(1);
                2'b01:   r_credits <= r_credits + c_CW'(1);
                default: r_credits <= r_credits;
            endcase
        end
    end

    // Looks one edge ahead so DONE is reached the cycle after the last pop.
    assign w_drained = !r_pipe_valid && ((r_tp_valid & ~c_TAIL_MASK) == '0) &&
                       (w_count_next == '0);

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_RUN:   if (flush)     w_state_next = c_DRAIN;
            c_DRAIN: if (w_drained) w_state_next = c_DONE;
            c_DONE:  if (!flush)    w_state_next = c_RUN;
            default: w_state_next = c_RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= c_RUN;
        else      r_state <= w_state_next;
    end

    assign pipe_valid = r_pipe_valid;
    assign pipe_data  = r_pipe_data;
    assign valid_ds   = (r_count != '0);
    assign data_ds    = r_fifo_data[r_rptr];
    assign id_ds      = r_fifo_id[r_rptr];
    assign flush_done = (r_state == c_DONE);
    assign err        = r_err;

endmodule
`default_nettype wire

// File: tb/tb_pipe_issue_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_issue_scheduler
// Description : Directed bench for pipe_issue_scheduler with a LAT-cycle
//               pipeline model (result = payload + 1).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_issue_scheduler;

    localparam int c_LAT = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [3:0]   valid_us = '0;
    logic [127:0] data_us = '0;
    logic [3:0]   stall_us;
    logic         pipe_valid;
    logic [31:0]  pipe_data;
    logic         ret_valid;
    logic [31:0]  ret_data;
    logic         valid_ds;
    logic [31:0]  data_ds;
    logic [1:0]   id_ds;
    logic         stall_ds = 1'b0;
    logic         flush = 1'b0;
    logic         flush_done;
    logic         err;
    logic         inject = 1'b0;

    int           checks = 0;
    int           failures = 0;
    int           k = 0;
    logic         prev_v = 1'b0;
    logic [31:0]  prev_d = '0;
    logic [1:0]   q_id[$];
    logic [31:0]  q_dat[$];

    logic [c_LAT-1:0] sh_v = '0;
    logic [31:0]      sh_d [c_LAT];

    pipe_issue_scheduler dut (
        .clk(clk), .rst(rst),
        .valid_us(valid_us), .data_us(data_us), .stall_us(stall_us),
        .pipe_valid(pipe_valid), .pipe_data(pipe_data),
        .ret_valid(ret_valid), .ret_data(ret_data),
        .valid_ds(valid_ds), .data_ds(data_ds), .id_ds(id_ds), .stall_ds(stall_ds),
        .flush(flush), .flush_done(flush_done), .err(err)
    );

    always #5 clk = ~clk;

    // Fixed-latency compute pipeline; deliberately unaffected by DUT reset.
    always @(posedge clk) begin
        sh_v    <= {sh_v[c_LAT-2:0], pipe_valid};
        sh_d[0] <= pipe_data;
        for (int s = 1; s < c_LAT; s++) sh_d[s] <= sh_d[s-1];
    end
    assign ret_valid = sh_v[c_LAT-1] | inject;
    assign ret_data  = sh_d[c_LAT-1] + 32'd1;

    function automatic logic [31:0] pay(input int i, input int kk);
        return 32'hD000_0000 | (32'(i) << 16) | 32'(kk & 16'hFFFF);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One cycle: drive at +1, check at the falling edge, expected grant g (-1 none).
    task automatic step(input logic [3:0] v, input int g, input logic sds, input int evds);
        logic [3:0] exp_stall;
        valid_us = v;
        stall_ds = sds;
        for (int i = 0; i < 4; i++) data_us[i*32 +: 32] = pay(i, k);
        #4;
        exp_stall = v;
        if (g >= 0) exp_stall[g] = 1'b0;
        chk("stall_us", 32'(stall_us), 32'(exp_stall));
        chk("pipe_valid", 32'(pipe_valid), 32'(prev_v));
        if (prev_v) chk("pipe_data", pipe_data, prev_d);
        if (evds >= 0) chk("valid_ds", 32'(valid_ds), 32'(evds));
        if (valid_ds && !sds) begin
            checks++;
            assert (q_id.size() != 0) else begin
                failures++;
                $error("FAIL unexpected_result observed=%0h expected=none", data_ds);
            end
            if (q_id.size() != 0) begin
                chk("id_ds", 32'(id_ds), 32'(q_id.pop_front()));
                chk("data_ds", data_ds, q_dat.pop_front());
            end
        end
        prev_v = (g >= 0);
        if (g >= 0) begin
            prev_d = pay(g, k);
            q_id.push_back(2'(g));
            q_dat.push_back(pay(g, k) + 32'd1);
        end
        k++;
        @(posedge clk); #1;
    endtask

    task automatic drain();
        for (int n = 0; n < 60 && q_id.size() > 0; n++) step(4'h0, -1, 1'b0, -1);
        chk("drain_left", 32'(q_id.size()), 32'd0);
    endtask

    initial begin
        #1 rst = 1'b0;
        @(posedge clk); #1;
        valid_us = 4'hF;
        #4;
        chk("rst_stall_us", 32'(stall_us), 32'hF);
        chk("rst_pipe_valid", 32'(pipe_valid), 32'd0);
        chk("rst_valid_ds", 32'(valid_ds), 32'd0);
        chk("rst_flush_done", 32'(flush_done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        valid_us = 4'h0;

        // Fairness: 0,1,2,3,0,1,2,3 and first result 10 cycles after first grant
        for (int r = 0; r < 8; r++) step(4'hF, r % 4, 1'b0, 0);
        step(4'h0, -1, 1'b0, 0);
        step(4'h0, -1, 1'b0, 0);
        step(4'h0, -1, 1'b0, 1);
        drain();

        // Sparse: move rr_ptr to 2, then 3,1,3,1
        step(4'b0010, 1, 1'b0, -1);
        step(4'b1010, 3, 1'b0, -1);
        step(4'b1010, 1, 1'b0, -1);
        step(4'b1010, 3, 1'b0, -1);
        step(4'b1010, 1, 1'b0, -1);
        drain();

        // Backpressure: 16 grants then stall, release, remaining 4 issue
        for (int r = 0; r < 16; r++) step(4'b0001, 0, 1'b1, -1);
        for (int r = 0; r < 14; r++) step(4'b0001, -1, 1'b1, -1);
        chk("bp_fifo_full", 32'(valid_ds), 32'd1);
        step(4'b0001, -1, 1'b0, 1);
        for (int r = 0; r < 4; r++) step(4'b0001, 0, 1'b0, -1);
        drain();

        // Flush with 5 in flight; the grant in the rising cycle still counts
        step(4'hF, 1, 1'b0, -1);
        step(4'hF, 2, 1'b0, -1);
        step(4'hF, 3, 1'b0, -1);
        step(4'hF, 0, 1'b0, -1);
        flush = 1'b1;
        step(4'hF, 1, 1'b0, -1);
        for (int n = 0; n < 40 && q_id.size() > 0; n++) begin
            step(4'hF, -1, 1'b0, -1);
            if (q_id.size() > 0) chk("flush_done_early", 32'(flush_done), 32'd0);
        end
        chk("flush_left", 32'(q_id.size()), 32'd0);
        chk("flush_done", 32'(flush_done), 32'd1);
        step(4'hF, -1, 1'b0, 0);
        flush = 1'b0;
        chk("flush_done_hold", 32'(flush_done), 32'd1);
        step(4'hF, -1, 1'b0, 0);
        step(4'hF, 2, 1'b0, 0);
        chk("flush_done_clear", 32'(flush_done), 32'd0);
        drain();

        // Spurious return with an empty tag pipe
        chk("err_before", 32'(err), 32'd0);
        inject = 1'b1;
        step(4'h0, -1, 1'b0, 0);
        inject = 1'b0;
        chk("err_set", 32'(err), 32'd1);
        step(4'h0, -1, 1'b0, 0);
        step(4'h0, -1, 1'b0, 0);
        chk("err_sticky", 32'(err), 32'd1);

        // Reset with 8 in flight
        step(4'hF, 3, 1'b1, -1);
        for (int r = 0; r < 7; r++) step(4'hF, r % 4, 1'b1, -1);
        rst = 1'b0;
        valid_us = 4'hF;
        #4;
        chk("mrst_stall_us", 32'(stall_us), 32'hF);
        chk("mrst_pipe_valid", 32'(pipe_valid), 32'd0);
        chk("mrst_err", 32'(err), 32'd0);
        chk("mrst_valid_ds", 32'(valid_ds), 32'd0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        q_id.delete();
        q_dat.delete();
        prev_v = 1'b0;
        step(4'hF, 0, 1'b1, 0);
        for (int r = 0; r < 15; r++) step(4'b0001, 0, 1'b1, -1);
        step(4'b0001, -1, 1'b1, -1);
        step(4'b0001, -1, 1'b1, -1);
        chk("mrst_late_err", 32'(err), 32'd1);
        drain();
        step(4'h0, -1, 1'b0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pipe_issue_scheduler.md
# pipe_issue_scheduler

Round-robin issue scheduler that shares one fixed-latency, non-stallable compute pipeline (for example a ray/box intersection unit) among NUM_IN valid/stall requesters. It sits between the requester-side arbiters and the pipeline. It reserves return-buffer space with a credit counter before issuing, so results are never dropped. It tags every issue with the requester index and returns each result with its tag through an internal return FIFO. A flush handshake drains all in-flight work for frame or scene changes.

## Interface
- NUM_IN, 4: number of requesters.
- WIDTH, 32: request payload width.
- RWIDTH, 32: result payload width.
- LAT, 8: pipeline latency in cycles from pipe_valid to ret_valid; must be ≥ 1.
- DEPTH, 16: return FIFO entries, equal to the total credits.
- ID_W, $clog2(NUM_IN): tag width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset (asserted when 0).
- valid_us  in  NUM_IN  per-requester request valid.
- data_us  in  NUM_IN×WIDTH  per-requester payload.
- stall_us  out  NUM_IN  per-requester stall; a request is accepted when valid_us[i] & ~stall_us[i].
- pipe_valid  out  1  registered issue strobe to the pipeline.
- pipe_data  out  WIDTH  registered issued payload.
- ret_valid  in  1  pipeline result strobe.
- ret_data  in  RWIDTH  pipeline result.
- valid_ds  out  1  return FIFO is non-empty.
- data_ds  out  RWIDTH  result at the FIFO head.
- id_ds  out  ID_W  requester tag of the FIFO head.
- stall_ds  in  1  downstream stall; the FIFO pops when valid_ds & ~stall_ds.
- flush  in  1  drain request, level-sensitive.
- flush_done  out  1  registered; 1 while drained and flush is still held.
- err  out  1  sticky; set when ret_valid disagrees with the internal in-flight tracking.

## Operation
- Grant:
  - Grant is allowed only when the state is RUN and credits > 0.
  - Among requesters with valid_us high, grant the first one found scanning from rr_ptr upward, wrapping modulo NUM_IN.
  - At most one grant per cycle.
  - stall_us = valid_us & ~grant, combinational.
- Round-robin pointer: on a grant to requester g, rr_ptr ← (g == NUM_IN−1) ? 0 : g+1. With no grant, rr_ptr holds.
- Issue register: captures data_us[g] and tag g. pipe_valid is 1 exactly in the cycle after a grant.
- Tag pipe:
  - A LAT-deep shift register carries {valid, tag} alongside the pipeline.
  - Its tail aligns with ret_valid.
  - When ret_valid is high, the FIFO is written with {tag_tail, ret_data}.
- Error check: if ret_valid ≠ tail valid in any cycle, err ← 1. err holds until reset. On a return with no matching tail entry, the FIFO is not written.
- Credit counter:
  - Width $clog2(DEPTH+1); resets to DEPTH.
  - Decrements on a grant and increments on a FIFO pop.
  - If both happen in the same cycle, the counter is unchanged.
  - Never underflows; never exceeds DEPTH.
- Return FIFO:
  - DEPTH entries with circular read and write pointers that wrap from DEPTH−1 to 0.
  - Write and pop in the same cycle are both honoured.
  - Credits guarantee the FIFO cannot overflow.
- FSM states:
  - RUN: grants are enabled. Go to DRAIN when flush = 1.
  - DRAIN: no grants. Go to DONE when the issue register, the tag pipe and the FIFO are all empty.
  - DONE: no grants; flush_done = 1. Go to RUN when flush = 0.
  - flush is sampled on clock edges only.
  - The grant that is combinationally visible in the cycle flush first rises is still honoured.
- Reset mid-operation: all in-flight and buffered results are discarded. No outputs are produced for them.

## Timing
- Reset values:
  - pipe_valid 0, valid_ds 0, flush_done 0, err 0.
  - rr_ptr 0, credits DEPTH, state RUN.
  - Tag pipe and FIFO empty.
  - stall_us = valid_us while rst = 0.
- Latencies:
  - grant cycle T → pipe_valid at T+1.
  - ret_valid at T+1+LAT → valid_ds at T+2+LAT.
- Throughput: one issue per cycle sustained while credits > 0 and stall_ds = 0.
- Credit exhaustion: with stall_ds held at 1, exactly DEPTH grants occur, then all stall_us follow valid_us.
- Credit return: a pop in cycle P allows a grant in cycle P+1.
- Drain: flush_done rises one cycle after the last FIFO pop.

## Test plan
- Fairness: all 4 valid continuously, stall_ds = 0 → grants 0,1,2,3,0,…; each result returns with id_ds matching its issuer; valid_ds first rises 10 cycles after the first grant (LAT = 8).
- Sparse requesters: only requesters 1 and 3 valid, rr_ptr = 2 → grants 3,1,3,1; payloads are returned in issue order.
- Backpressure: stall_ds = 1 while requester 0 sends 20 requests → exactly 16 grants, then stall_us[0] = 1. Release stall_ds → 16 pops, the remaining 4 are issued, and no result is lost.
- Flush: flush rises with 5 results in flight → no new grants; flush_done = 1 after the 5th pop; flush = 0 → RUN, and grants resume the next cycle.
- Error: inject a spurious ret_valid with the tag pipe empty → err = 1 and stays 1; the FIFO count is unchanged.
- Reset mid-stream: drive rst = 0 with 8 in flight, then release → valid_ds = 0, credits are 16, rr_ptr is 0, and late ret_valid pulses set err.
